// File: rtl/io_ring_pkg.sv
// Shared types and defaults for the IO pad-ring power sequencer.
package io_ring_pkg;

    // Sequencer states; the top keeps its state register as plain logic
    // constants derived from these values.
    typedef enum logic [2:0] {
        IO_OFF     = 3'd0,
        IO_DBNC    = 3'd1,
        IO_RAMP_UP = 3'd2,
        IO_ON      = 3'd3,
        IO_RAMP_DN = 3'd4
    } io_seq_state_e;

    // Default drive-strength code width and reset value.
    localparam int IO_DS_W_DEF   = 2;
    localparam int IO_DS_RST_DEF = 0;

    // Largest ring this sequencer supports; sizes the group index.
    localparam int IO_MAX_GROUPS = 8;

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer for asynchronous ring status inputs.
module io_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two register stages give the first flop a full cycle to resolve.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/io_ring_pwr_seq.sv
// Power-up / power-down sequencer for one IO pad ring.
// Optional feature macro: IORING_SEQ_FAULT_EN -- supply loss while the ring
// is up drops every output enable at once and sets a sticky fault.
module io_ring_pwr_seq
    import io_ring_pkg::*;
#(
    parameter int N_GROUPS     = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int SETTLE_CYC   = 8,
    parameter int DS_W         = IO_DS_W_DEF,
    parameter int DS_RST       = IO_DS_RST_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     vddio_ok_i,
    input  logic                     en_req_i,
    output logic [N_GROUPS-1:0]      grp_oe_o,
    output logic [N_GROUPS*DS_W-1:0] grp_ds_o,
    output logic                     ret_o,
    output logic                     ready_o,
    output logic                     busy_o,
    output logic                     fault_o,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic [2:0]               cfg_grp_i,
    input  logic [DS_W-1:0]          cfg_ds_i
);

    localparam logic [2:0] S_OFF     = IO_OFF;
    localparam logic [2:0] S_DBNC    = IO_DBNC;
    localparam logic [2:0] S_RAMP_UP = IO_RAMP_UP;
    localparam logic [2:0] S_ON      = IO_ON;
    localparam logic [2:0] S_RAMP_DN = IO_RAMP_DN;

    localparam int CNT_MAX = (DEBOUNCE_CYC > SETTLE_CYC) ? DEBOUNCE_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int GRP_W   = $clog2(IO_MAX_GROUPS);

    localparam logic [CNT_W-1:0]    DBNC_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYC);
    localparam logic [GRP_W-1:0]    K_LAST      = GRP_W'(N_GROUPS - 1);
    localparam logic [N_GROUPS-1:0] GRP_ONE     = N_GROUPS'(1);

    logic                vok;
    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [GRP_W-1:0]    k_q, k_d, k_up, k_dn;
    logic [N_GROUPS-1:0] oe_q, oe_d;
    logic                ret_q, ready_q, busy_q, cfg_ready_q;
    logic [N_GROUPS*DS_W-1:0] ds_q;
    logic                fault_q;
    logic                cfg_accept;

    io_sync2 #(.WIDTH(1)) u_vok_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (vddio_ok_i),
        .q_o   (vok)
    );

    // Settle/debounce counter never wraps; it parks at all-ones.
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign k_up       = k_q + GRP_W'(1);
    assign k_dn       = k_q - GRP_W'(1);
    assign cfg_accept = cfg_valid_i && cfg_ready_q;

`ifdef IORING_SEQ_FAULT_EN
    logic fault_set;
`endif

    // Next-state, group index and output-enable pattern for the sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        oe_d    = oe_q;
`ifdef IORING_SEQ_FAULT_EN
        fault_set = 1'b0;
`endif
        case (state_q)
            S_OFF: begin
                cnt_d = '0;
                k_d   = '0;
                if (en_req_i && vok && !fault_q) begin
                    state_d = S_DBNC;
                end
            end
            S_DBNC: begin
                if (!vok) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == DBNC_LAST) begin
                    state_d = S_RAMP_UP;
                    cnt_d   = '0;
                    k_d     = '0;
                    oe_d    = oe_q | GRP_ONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RAMP_UP, S_ON: begin
`ifdef IORING_SEQ_FAULT_EN
                if (!vok) begin
                    state_d   = S_OFF;
                    oe_d      = '0;
                    cnt_d     = '0;
                    k_d       = '0;
                    fault_set = 1'b1;
                end else
`endif
                if (!en_req_i || !vok) begin
                    // Reverse from the highest group currently enabled.
                    state_d = S_RAMP_DN;
                    oe_d    = oe_q & ~(GRP_ONE << k_q);
                    cnt_d   = '0;
                end else if (state_q == S_RAMP_UP) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d = '0;
                        if (k_q == K_LAST) begin
                            state_d = S_ON;
                        end else begin
                            k_d  = k_up;
                            oe_d = oe_q | (GRP_ONE << k_up);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_RAMP_DN: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (k_q == '0) begin
                        state_d = S_OFF;
                    end else begin
                        k_d  = k_dn;
                        oe_d = oe_q & ~(GRP_ONE << k_dn);
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_OFF;
                oe_d    = '0;
                cnt_d   = '0;
                k_d     = '0;
            end
        endcase
    end

    // Sequencer state plus registered status outputs decoded from next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_OFF;
            cnt_q       <= '0;
            k_q         <= '0;
            oe_q        <= '0;
            ret_q       <= 1'b1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            oe_q        <= oe_d;
            ret_q       <= (state_d == S_OFF) || (state_d == S_DBNC);
            ready_q     <= (state_d == S_ON);
            busy_q      <= (state_d == S_DBNC) || (state_d == S_RAMP_UP) ||
                           (state_d == S_RAMP_DN);
            cfg_ready_q <= (state_d == S_OFF) || (state_d == S_ON);
        end
    end

    // Per-group drive-strength registers written through the cfg handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: this small register array is reset (unlike a RAM) because pads must see a defined drive strength.
            ds_q <= {N_GROUPS{DS_W'(DS_RST)}};
        end else if (cfg_accept) begin
            // Indices at or above N_GROUPS match no group and are dropped.
            for (int g = 0; g < N_GROUPS; g++) begin
                if (cfg_grp_i == 3'(g)) begin
                    ds_q[g*DS_W +: DS_W] <= cfg_ds_i;
                end
            end
        end
    end

`ifdef IORING_SEQ_FAULT_EN
    // Sticky supply-loss fault; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_q <= 1'b0;
        end else if (fault_set) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign fault_q = 1'b0;
`endif

    assign grp_oe_o    = oe_q;
    assign grp_ds_o    = ds_q;
    assign ret_o       = ret_q;
    assign ready_o     = ready_q;
    assign busy_o      = busy_q;
    assign fault_o     = fault_q;
    assign cfg_ready_o = cfg_ready_q;

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Self-checking bench for io_ring_pwr_seq: directed scenarios followed by
// randomized stimulus, all compared against a cycle-level reference model.
// Honours IORING_SEQ_FAULT_EN when it is defined for the whole build.
module tb_io_ring_pwr_seq;

    localparam int N  = 4;
    localparam int D  = 16;
    localparam int S  = 8;
    localparam int DW = 2;
    localparam int DR = 0;

`ifdef IORING_SEQ_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, vddio_ok, en_req, cfg_valid;
    logic [2:0]    cfg_grp;
    logic [DW-1:0] cfg_ds;
    logic [N-1:0]    grp_oe;
    logic [N*DW-1:0] grp_ds;
    logic ret, ready, busy, fault, cfg_ready;

    io_ring_pwr_seq #(
        .N_GROUPS(N), .DEBOUNCE_CYC(D), .SETTLE_CYC(S), .DS_W(DW), .DS_RST(DR)
    ) dut (
        .clk_i(clk), .rst_i(rst), .vddio_ok_i(vddio_ok), .en_req_i(en_req),
        .grp_oe_o(grp_oe), .grp_ds_o(grp_ds), .ret_o(ret), .ready_o(ready),
        .busy_o(busy), .fault_o(fault), .cfg_valid_i(cfg_valid),
        .cfg_ready_o(cfg_ready), .cfg_grp_i(cfg_grp), .cfg_ds_i(cfg_ds)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phases with a countdown to the next event and a count
    // of enabled groups (enables are always a contiguous low-order block).
    typedef enum int {M_IDLE, M_WAIT, M_UP, M_FULL, M_DOWN} mphase_t;
    mphase_t       ph;
    int            left, on_cnt;
    bit            m_fault, m_cfg_rdy, s1, s2;
    logic [DW-1:0] ds_m [N];

    task automatic model_step();
        bit vok;
        if (rst) begin
            ph = M_IDLE; left = 0; on_cnt = 0; m_fault = 0; m_cfg_rdy = 0;
            s1 = 0; s2 = 0;
            for (int g = 0; g < N; g++) ds_m[g] = DW'(DR);
            return;
        end
        vok = s2;
        if (cfg_valid && m_cfg_rdy && int'(cfg_grp) < N) ds_m[cfg_grp] = cfg_ds;
        case (ph)
            M_IDLE: if (en_req && vok && !m_fault) begin ph = M_WAIT; left = D; end
            M_WAIT: begin
                if (!vok) ph = M_IDLE;
                else begin
                    left--;
                    if (left == 0) begin ph = M_UP; on_cnt = 1; left = S + 1; end
                end
            end
            M_UP, M_FULL: begin
                if (FAULT_EN && !vok) begin
                    ph = M_IDLE; on_cnt = 0; m_fault = 1;
                end else if (!en_req || !vok) begin
                    ph = M_DOWN; on_cnt--; left = S + 1;
                end else if (ph == M_UP) begin
                    left--;
                    if (left == 0) begin
                        if (on_cnt == N) ph = M_FULL;
                        else begin on_cnt++; left = S + 1; end
                    end
                end
            end
            M_DOWN: begin
                left--;
                if (left == 0) begin
                    if (on_cnt == 0) ph = M_IDLE;
                    else begin on_cnt--; left = S + 1; end
                end
            end
            default: ph = M_IDLE;
        endcase
        s2 = s1;
        s1 = vddio_ok;
        m_cfg_rdy = (ph == M_IDLE) || (ph == M_FULL);
    endtask

    function automatic logic [N*DW-1:0] ds_exp();
        logic [N*DW-1:0] p;
        for (int g = 0; g < N; g++) p[g*DW +: DW] = ds_m[g];
        return p;
    endfunction

    task automatic compare_all();
        check("oe",        grp_oe,    (1 << on_cnt) - 1);
        check("ds",        grp_ds,    ds_exp());
        check("ret",       ret,       (ph == M_IDLE) || (ph == M_WAIT));
        check("ready",     ready,     ph == M_FULL);
        check("busy",      busy,      (ph == M_WAIT) || (ph == M_UP) || (ph == M_DOWN));
        check("fault",     fault,     m_fault);
        check("cfg_ready", cfg_ready, m_cfg_rdy);
    endtask

    // One clock: model advances on the edge, outputs compared mid-cycle.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int step_t [4];
        int nsteps, ready_t, tz, tr, n;
        bit seen_off, pend, reached;
        logic [N-1:0] prev_oe;

        rst = 1; vddio_ok = 0; en_req = 0; cfg_valid = 0; cfg_grp = 0; cfg_ds = 0;
        repeat (3) tick();
        check("rst_oe", grp_oe, 0);
        check("rst_ret", ret, 1);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_ds", grp_ds, 0);
        rst = 0;
        tick();
        check("cfg_ready_after_rst", cfg_ready, 1);

        // Power-up: record the tick of every enable step.
        en_req = 1; vddio_ok = 1;
        for (int i = 0; i < 4; i++) step_t[i] = -100;
        nsteps = 0; ready_t = -100; prev_oe = '0;
        for (int t = 1; t <= 200; t++) begin
            tick();
            if (grp_oe != prev_oe) begin
                if (nsteps < 4) step_t[nsteps] = t;
                nsteps++;
                prev_oe = grp_oe;
            end
            if (ready) begin ready_t = t; break; end
        end
        check("pu_first_step", step_t[0], D + 3);
        for (int i = 1; i < 4; i++) check("pu_step_gap", step_t[i] - step_t[i-1], S + 1);
        check("pu_ready_gap", ready_t - step_t[3], S + 1);
        check("pu_oe_full", grp_oe, 4'hF);
        check("pu_ret_low", ret, 0);

        // Configuration in ON, then an out-of-range group.
        cfg_valid = 1; cfg_grp = 2; cfg_ds = 3;
        tick();
        cfg_valid = 0;
        check("cfg_g2", grp_ds[5:4], 3);
        cfg_valid = 1; cfg_grp = 6; cfg_ds = 1;
        tick();
        cfg_valid = 0;
        check("cfg_oob", grp_ds, 8'h30);

        // Write coinciding with en_req fall, then ordered power-down.
        en_req = 0; cfg_valid = 1; cfg_grp = 1; cfg_ds = 2;
        tick();
        cfg_valid = 0;
        check("cfg_at_drop", grp_ds[3:2], 2);
        check("pd_first", grp_oe, 4'b0111);
        tz = -100; tr = -100;
        for (int t = 1; t <= 100; t++) begin
            tick();
            if (grp_oe == 0 && tz < 0) tz = t;
            if (ret) begin tr = t; break; end
        end
        check("pd_oe_zero", tz, 3 * (S + 1));
        check("pd_ret_gap", tr - tz, S + 1);

        // Debounce glitch at count 10.
        vddio_ok = 0;
        repeat (3) tick();
        en_req = 1; vddio_ok = 1;
        repeat (13) tick();
        vddio_ok = 0;
        tick();
        vddio_ok = 1;
        n = -100; seen_off = 0;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (!busy) seen_off = 1;
            if (grp_oe != 0) begin n = t; break; end
        end
        check("glitch_off", seen_off, 1);
        check("glitch_recover", n, D + 3);

        // Abort mid-ramp at 0011.
        reached = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (grp_oe == 4'b0011) begin reached = 1; break; end
        end
        check("abort_reach", reached, 1);
        en_req = 0;
        tick();
        check("abort_step1", grp_oe, 4'b0001);
        repeat (S) tick();
        check("abort_hold", grp_oe, 4'b0001);
        tick();
        check("abort_step2", grp_oe, 4'b0000);
        check("abort_ret_low", ret, 0);
        repeat (S + 1) tick();
        check("abort_ret", ret, 1);

        // Write issued during RAMP_UP waits for ON.
        en_req = 1;
        reached = 0;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (grp_oe == 4'b0001) begin reached = 1; break; end
        end
        check("up2_reach", reached, 1);
        cfg_valid = 1; cfg_grp = 0; cfg_ds = 1;
        check("cfg_blocked_up", cfg_ready, 0);
        n = -100;
        for (int t = 1; t <= 100; t++) begin
            tick();
            if (cfg_ready) begin n = t; break; end
        end
        check("cfg_wait_on", n, N * (S + 1));
        check("cfg_ready_in_on", ready, 1);
        tick();
        cfg_valid = 0;
        check("cfg_g0", grp_ds[1:0], 1);

        // Supply loss in ON.
        vddio_ok = 0;
        n = -100;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (grp_oe == 0) begin n = t; break; end
        end
`ifdef IORING_SEQ_FAULT_EN
        check("loss_fast", n >= 1 && n <= 3, 1);
        check("loss_fault", fault, 1);
        en_req = 0;
        tick();
        en_req = 1; vddio_ok = 1;
        repeat (30) tick();
        check("fault_sticky", fault, 1);
        check("fault_ignores_en", grp_oe, 0);
`else
        check("loss_ordered", n, 3 + 3 * (S + 1));
        check("loss_no_fault", fault, 0);
        vddio_ok = 1;
`endif
        rst = 1;
        tick();
        rst = 0;
        tick();

        // Reset in the middle of RAMP_UP.
        en_req = 1; vddio_ok = 1;
        reached = 0;
        for (int t = 1; t <= 80; t++) begin
            tick();
            if (grp_oe == 4'b0011) begin reached = 1; break; end
        end
        check("rup_reach", reached, 1);
        rst = 1;
        tick();
        check("rup_rst_oe", grp_oe, 0);
        check("rup_rst_ret", ret, 1);
        check("rup_rst_busy", busy, 0);
        check("rup_rst_ready", ready, 0);
        check("rup_rst_cfg_ready", cfg_ready, 0);
        check("rup_rst_ds", grp_ds, 0);
        rst = 0;
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            if (rst) rst = 0;
            else if ($urandom_range(0, 399) == 0) rst = 1;
            if ($urandom_range(0, 99) == 0) en_req = ~en_req;
            if ($urandom_range(0, 149) == 0) vddio_ok = ~vddio_ok;
            if (!cfg_valid && $urandom_range(0, 7) == 0) begin
                cfg_valid = 1;
                cfg_grp   = 3'($urandom_range(0, 7));
                cfg_ds    = DW'($urandom);
            end
            pend = cfg_valid && m_cfg_rdy && !rst;
            tick();
            if (pend) cfg_valid = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
